// File: rtl/bus_grant_arbiter_pkg.sv
// bus_arb_pkg: shared state encoding and parameter defaults for the bus grant arbiter
package bus_arb_pkg;
  localparam int N_SRC_DEF = 32;
  localparam int HOLD_MAX_DEF = 15;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
endpackage

// File: rtl/bus_grant_arbiter_if.sv
// bus_grant_arbiter_if: request/grant bundle between bus sources and the arbiter
interface bus_grant_arbiter_if #(parameter int N_SRC = bus_arb_pkg::N_SRC_DEF);
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic done;
  logic grant_valid;
  logic busy;
  logic timeout;
  modport master (input req, done, output grant, grant_valid, busy, timeout);
  modport slave (output req, done, input grant, grant_valid, busy, timeout);
endinterface

// File: rtl/bus_grant_arbiter_rr_pick.sv
// rr_pick: lowest-indexed requester strictly above last_i, wrapping modulo N_SRC
module rr_pick import bus_arb_pkg::*; #(
  parameter int N_SRC = N_SRC_DEF,
  localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_SRC-1:0] pick_o,
  output logic [IW-1:0]    idx_o
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest candidate above last_i wins.
  always_comb begin
    pick_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % N_SRC);
      if (req_i[j]) begin
        pick_o = '0;
        pick_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin bus owner arbiter with release turnaround cycle.
// Define BUS_ARB_TIMEOUT_EN to revoke grants held for HOLD_MAX cycles.
module bus_grant_arbiter import bus_arb_pkg::*; #(
  parameter int N_SRC = N_SRC_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input logic clk,
  input logic rst_n,
  bus_grant_arbiter_if.master bus
);
  state_t state_q;
  logic [N_SRC-1:0] grant_q, pick_d;
  logic [IW-1:0] last_q, idx_d;
  logic gv_q, busy_q, to_q;
  logic rel, expire;

  rr_pick #(.N_SRC(N_SRC)) u_pick (.req_i(bus.req), .last_i(last_q), .pick_o(pick_d), .idx_o(idx_d));

  assign rel = bus.done | ~bus.req[last_q];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_MAX - 1);
  logic [HW-1:0] hold_q;
  // Cleared while idle so it reads zero in the first GRANT cycle.
  always_ff @(posedge clk)
    if (!rst_n || state_q == IDLE) hold_q <= '0;
    else if (state_q == GRANT && hold_q != HMAX) hold_q <= hold_q + HW'(1);
  assign expire = hold_q >= HLAST;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q <= 1'b0;
      busy_q <= 1'b0;
      to_q <= 1'b0;
      last_q <= IW'(N_SRC - 1);
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: if (|bus.req) begin
          state_q <= GRANT;
          grant_q <= pick_d;
          last_q <= idx_d;
          gv_q <= 1'b1;
          busy_q <= 1'b1;
        end
        GRANT: if (rel | expire) begin
          state_q <= TURN;
          grant_q <= '0;
          gv_q <= 1'b0;
          to_q <= ~rel & expire;
        end
        TURN: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.busy = busy_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed and randomized checks of bus_grant_arbiter against a cycle reference model
module tb_bus_grant_arbiter;
  localparam int N = 32;
  localparam int HOLD_MAX = 15;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;

  bus_grant_arbiter_if #(.N_SRC(N)) bus ();
  bus_grant_arbiter #(.N_SRC(N), .HOLD_MAX(HOLD_MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int m_own, m_last, m_hold;
  bit m_turn, m_to;

  task automatic model_update(input logic r, input logic [N-1:0] rq, input logic dn);
    if (!r) begin
      m_own = -1; m_turn = 0; m_last = N - 1; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_own >= 0) begin
        if (dn || !rq[m_own]) begin m_own = -1; m_turn = 1; end
        else if (TO_EN && m_hold >= HOLD_MAX) begin m_own = -1; m_turn = 1; m_to = 1; end
        else m_hold++;
      end else if (m_turn) m_turn = 0;
      else if (rq != '0) begin
        for (int k = N; k >= 1; k--) if (rq[(m_last + k) % N]) m_own = (m_last + k) % N;
        m_last = m_own;
        m_hold = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic dn);
    rst_n = r; bus.req = rq; bus.done = dn;
    @(posedge clk);
    model_update(r, rq, dn);
    #1;
  endtask

  task automatic test_reset();
    step(1, 32'h0000_00ff, 0);
    step(0, 32'h0000_00ff, 0);
    checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant got=%h exp=0", bus.grant); end
    checks++; if (bus.grant_valid !== 1'b0) begin failures++; $display("FAIL reset_gv got=%b exp=0", bus.grant_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
  endtask

  task automatic test_basic();
    step(0, '0, 0);
    step(1, 32'h5, 0);
    checks++; if (bus.grant !== 32'h1) begin failures++; $display("FAIL first_grant got=%h exp=%h", bus.grant, 32'h1); end
    checks++; if (bus.busy !== 1'b1 || bus.grant_valid !== 1'b1) begin failures++; $display("FAIL first_busy got=%b%b exp=11", bus.busy, bus.grant_valid); end
    step(1, 32'h5, 1);
    checks++; if (bus.grant !== '0 || bus.busy !== 1'b1) begin failures++; $display("FAIL done_turn got=%h/%b exp=0/1", bus.grant, bus.busy); end
    step(1, 32'h5, 0);
    checks++; if (bus.grant !== '0 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_idle got=%h/%b exp=0/0", bus.grant, bus.busy); end
    step(1, 32'h5, 0);
    checks++; if (bus.grant !== 32'h4) begin failures++; $display("FAIL rr_next got=%h exp=%h", bus.grant, 32'h4); end
    step(1, 32'h5, 1);
    step(1, 32'h5, 0);
    step(1, 32'h5, 0);
    checks++; if (bus.grant !== 32'h1) begin failures++; $display("FAIL rr_wrap got=%h exp=%h", bus.grant, 32'h1); end
    step(1, 32'h1, 0);
    checks++; if (bus.grant !== 32'h1) begin failures++; $display("FAIL hold_const got=%h exp=%h", bus.grant, 32'h1); end
    step(1, 32'h4, 0);
    checks++; if (bus.grant !== '0 || bus.busy !== 1'b1) begin failures++; $display("FAIL req_drop got=%h/%b exp=0/1", bus.grant, bus.busy); end
  endtask

  task automatic test_wrap();
    step(0, '0, 0);
    step(1, 32'h8000_0000, 0);
    checks++; if (bus.grant !== 32'h8000_0000) begin failures++; $display("FAIL top_first got=%h exp=80000000", bus.grant); end
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h8000_0000, 1);
      checks++; if (bus.grant !== '0 || bus.grant_valid !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL top_turn got=%h/%b/%b exp=0/0/1", bus.grant, bus.grant_valid, bus.busy); end
      step(1, 32'h8000_0000, 0);
      checks++; if (bus.grant !== '0 || bus.busy !== 1'b0) begin failures++; $display("FAIL top_idle got=%h/%b exp=0/0", bus.grant, bus.busy); end
      step(1, 32'h8000_0000, 0);
      checks++; if (bus.grant !== 32'h8000_0000) begin failures++; $display("FAIL top_regrant got=%h exp=80000000", bus.grant); end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    step(0, '0, 0);
    step(1, 32'h1, 0);
    n = 1; seen = 0;
    for (int c = 0; c < 120 && bus.grant !== '0; c++) begin
      step(1, 32'h1, 0);
      if (bus.grant !== '0) n++;
      if (bus.grant !== '0 && bus.timeout !== 1'b0) seen = 1;
    end
    if (TO_EN) begin
      checks++; if (n != HOLD_MAX) begin failures++; $display("FAIL to_len got=%0d exp=%0d", n, HOLD_MAX); end
      checks++; if (bus.timeout !== 1'b1 || bus.grant !== '0) begin failures++; $display("FAIL to_pulse got=%b/%h exp=1/0", bus.timeout, bus.grant); end
      step(1, 32'h1, 0);
      checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL to_width got=%b exp=0", bus.timeout); end
    end else begin
      checks++; if (n != 121) begin failures++; $display("FAIL hold_unlimited got=%0d exp=121", n); end
      checks++; if (seen || bus.timeout !== 1'b0) begin failures++; $display("FAIL to_tied got=%b exp=0", seen | bus.timeout); end
    end
  endtask

  task automatic test_reset_mid();
    step(0, '0, 0);
    step(1, 32'h400, 0);
    step(1, 32'h400, 0);
    checks++; if (bus.grant !== 32'h400) begin failures++; $display("FAIL mid_pre got=%h exp=400", bus.grant); end
    step(0, 32'h400, 0);
    checks++; if (bus.grant !== '0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mid_drop got=%h/%b exp=0/0", bus.grant, bus.busy); end
    step(1, 32'h400, 0);
    checks++; if (bus.grant !== 32'h400) begin failures++; $display("FAIL mid_regrant got=%h exp=400", bus.grant); end
  endtask

  task automatic test_random();
    logic [N-1:0] rq, eg;
    logic r, dn;
    int wt[N];
    int prev_own, bad;
    step(0, '0, 0);
    foreach (wt[i]) wt[i] = 0;
    rq = '0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(9) == 0) rq = ($urandom_range(7) == 0) ? '0 : N'($urandom & $urandom & $urandom);
      dn = ($urandom_range(11) == 0);
      r = ($urandom_range(499) != 0);
      prev_own = m_own;
      step(r, rq, dn);
      eg = '0;
      if (m_own >= 0) eg[m_own] = 1'b1;
      checks++;
      if (bus.grant !== eg || bus.grant_valid !== (m_own >= 0) || bus.busy !== (m_own >= 0 || m_turn) || bus.timeout !== m_to) begin
        failures++;
        $display("FAIL rand_c%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", c, bus.grant, bus.grant_valid, bus.busy, bus.timeout, eg, m_own >= 0, m_own >= 0 || m_turn, m_to);
      end
      checks++; if (!$onehot0(bus.grant)) begin failures++; $display("FAIL rand_onehot got=%h exp=onehot0", bus.grant); end
      for (int i = 0; i < N; i++) begin
        if (!r || !rq[i] || i == m_own) wt[i] = 0;
        else if (m_own >= 0 && prev_own < 0) wt[i]++;
        if (wt[i] > N) bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_starve got=%0d exp=0", bad); end
  endtask

  initial begin
    rst_n = 1'b0; bus.req = '0; bus.done = 1'b0;
    m_own = -1; m_turn = 0; m_last = N - 1; m_hold = 0; m_to = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_grant_arbiter.md
BUS_GRANT_ARBITER -- requirements
Module: bus_grant_arbiter

Interface
REQ-001 The block SHALL take parameter N_SRC, default 32, as the number of bus sources; the output grant word SHALL be N_SRC bits wide.
REQ-002 The block SHALL take parameter HOLD_MAX, default 15, as the maximum number of cycles one source may hold the bus.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req  input  N_SRC  per-source bus-drive request, level-sensitive.
REQ-007 done  input  1  the current owner signals that its transfer is complete.
REQ-008 grant  output  N_SRC  registered grant word, always zero or one-hot; this word drives the downstream 32:5 bus-select encoder.
REQ-009 grant_valid  output  1  high exactly when grant is one-hot.
REQ-010 busy  output  1  high in GRANT and TURN.
REQ-011 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and TURN.
REQ-013 IDLE: if req is non-zero, the block SHALL select the lowest-indexed requesting source strictly above last_owner, wrapping modulo N_SRC, then register its one-hot grant and enter GRANT on the next edge. Latency from request to grant SHALL be 1 cycle.
REQ-014 IDLE with req equal to zero: the block SHALL stay in IDLE with grant=0 and grant_valid=0.
REQ-015 GRANT: grant SHALL stay constant while req[owner]=1 and done=0.
REQ-016 GRANT: if done=1 or req[owner]=0, the block SHALL clear grant and enter TURN on the next edge; done=1 and req[owner]=0 together SHALL be treated as a single release.
REQ-017 TURN: the block SHALL hold grant=0 for exactly one cycle (bus turnaround) and then return to IDLE; requests seen during TURN SHALL be arbitrated only in IDLE.
REQ-018 last_owner SHALL update to the owner index on every entry to GRANT; the requesting owner SHALL have the lowest priority in the next arbitration.
REQ-019 If only the previous owner requests, the block SHALL grant it again after the IDLE cycle (wrap-around case).
REQ-020 A grant SHALL never be zero in GRANT and SHALL never have more than one bit set in any state.
REQ-021 The hold counter SHALL be $clog2(HOLD_MAX+1) bits wide, SHALL clear on GRANT entry, SHALL increment each GRANT cycle, and SHALL saturate without wrapping.

Reset
REQ-022 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set grant=0, grant_valid=0, busy=0, timeout=0, hold counter=0 and last_owner=N_SRC-1, so that source 0 wins first.
REQ-023 A reset asserted during GRANT SHALL drop grant on the same edge, with no TURN cycle.

Configuration
REQ-024 With macro BUS_ARB_TIMEOUT_EN defined: when the hold counter reaches HOLD_MAX in GRANT, the block SHALL clear grant, pulse timeout for one cycle, and enter TURN. A done or request drop in the same cycle SHALL take precedence, and no timeout pulse SHALL be raised.
REQ-025 Without BUS_ARB_TIMEOUT_EN: hold SHALL be unlimited, timeout SHALL be tied to 0, and the hold counter SHALL be absent.

Structure
REQ-026 Package bus_arb_pkg SHALL hold the state enum (IDLE, GRANT, TURN), the N_SRC default (32) and the HOLD_MAX default.
REQ-027 The block SHALL contain one combinational sub-module, rr_pick, that maps (req, last_owner) to a one-hot pick and its index.

Verification
REQ-028 Reset, then req=32'h0000_0005 -> grant=32'h1 one cycle later, busy=1.
REQ-029 Owner 0 asserts done with req=32'h5 held -> one TURN cycle with grant=0, then grant=32'h4; after that release -> grant=32'h1 (wrap-around).
REQ-030 req=32'h8000_0000 only, repeated release -> grant=32'h8000_0000, TURN, IDLE, grant=32'h8000_0000 again; grant_valid=0 in TURN.
REQ-031 Timeout enabled, HOLD_MAX=15, owner never releases -> grant clears after 15 GRANT cycles, timeout=1 for exactly 1 cycle; disabled build -> grant held for 100+ cycles with timeout=0.
REQ-032 rst_n=0 mid-GRANT with grant=32'h400 -> grant=0 at that edge; with req=32'h400 still high after reset -> grant=32'h400 (last_owner=31 after reset).
REQ-033 Random req for 10k cycles -> grant always zero or one-hot, and no requester starves for more than N_SRC grants.
